// File: rtl/multi_ch_sync_fifo.sv
// multi_ch_sync_fifo: NUM_CH logical FIFOs sharing one storage array, CH_DEPTH entries each,
// with a registered read path. Optional sticky error flags enabled by MCFIFO_ERR_FLAGS_EN.
`default_nettype none

module multi_ch_sync_fifo #(
  parameter type DTYPE    = logic [7:0],
  parameter int  NUM_CH   = 4,
  parameter int  CH_DEPTH = 16,
  parameter int  CH_AW    = $clog2(CH_DEPTH),
  parameter int  CW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int  AFULL_TH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_clear,
  input  logic                          i_wen,
  input  logic [CW-1:0]                 i_wch,
  input  DTYPE                          i_wdata,
  input  logic                          i_ren,
  input  logic [CW-1:0]                 i_rch,
  output DTYPE                          o_rdata,
  output logic                          o_rvalid,
  output logic [CW-1:0]                 o_rch_q,
  output logic [NUM_CH-1:0]             o_empty,
  output logic [NUM_CH-1:0]             o_full,
  output logic [NUM_CH-1:0]             o_afull,
  output logic [NUM_CH-1:0][CH_AW:0]    o_count,
  output logic [NUM_CH-1:0]             o_overflow,
  output logic [NUM_CH-1:0]             o_underflow
);

  localparam int             c_CNT_W     = CH_AW + 1;
  localparam int             c_MEM_DEPTH = NUM_CH * CH_DEPTH;
  localparam int             c_AW        = (c_MEM_DEPTH > 1) ? $clog2(c_MEM_DEPTH) : 1;
  localparam logic [CW:0]    c_NCH       = (CW+1)'(NUM_CH);
  localparam logic [c_CNT_W-1:0] c_FULL_LVL  = c_CNT_W'(CH_DEPTH);
  localparam logic [c_CNT_W-1:0] c_AFULL_LVL = c_CNT_W'(CH_DEPTH - AFULL_TH);
  localparam logic [CH_AW-1:0]   c_PTR_LAST  = CH_AW'(CH_DEPTH - 1);

  DTYPE                 r_mem   [c_MEM_DEPTH];
  logic [CH_AW-1:0]     r_wptr  [NUM_CH];
  logic [CH_AW-1:0]     r_rptr  [NUM_CH];
  logic [c_CNT_W-1:0]   r_count [NUM_CH];
  DTYPE                 r_rdata;
  logic                 r_rvalid;
  logic [CW-1:0]        r_rch_q;

  logic                 w_wch_ok;
  logic                 w_rch_ok;
  logic                 w_wr_ok;
  logic                 w_rd_ok;
  logic [c_AW-1:0]      w_waddr;
  logic [c_AW-1:0]      w_raddr;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      o_count[c] = r_count[c];
      o_empty[c] = (r_count[c] == '0);
      o_full[c]  = (r_count[c] == c_FULL_LVL);
      o_afull[c] = (r_count[c] >= c_AFULL_LVL);
    end
  end

  // Range check comes first so an out-of-range index never qualifies a flag lookup.
  assign w_wch_ok = ({1'b0, i_wch} < c_NCH);
  assign w_rch_ok = ({1'b0, i_rch} < c_NCH);
  assign w_wr_ok  = i_wen && w_wch_ok && !o_full[i_wch]  && !i_clear;
  assign w_rd_ok  = i_ren && w_rch_ok && !o_empty[i_rch] && !i_clear;

  assign w_waddr = c_AW'(i_wch) * c_AW'(CH_DEPTH) + c_AW'(r_wptr[i_wch]);
  assign w_raddr = c_AW'(i_rch) * c_AW'(CH_DEPTH) + c_AW'(r_rptr[i_rch]);

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[w_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_wptr[c]  <= '0;
        r_rptr[c]  <= '0;
        r_count[c] <= '0;
      end
    end else if (i_clear) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_wptr[c]  <= '0;
        r_rptr[c]  <= '0;
        r_count[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_wr_ok && (i_wch == CW'(c)))
          r_wptr[c] <= (r_wptr[c] == c_PTR_LAST) ? '0 : r_wptr[c] + 1'b1;
        if (w_rd_ok && (i_rch == CW'(c)))
          r_rptr[c] <= (r_rptr[c] == c_PTR_LAST) ? '0 : r_rptr[c] + 1'b1;
        case ({w_wr_ok && (i_wch == CW'(c)), w_rd_ok && (i_rch == CW'(c))})
          2'b10:   r_count[c] <= r_count[c] + 1'b1;
          2'b01:   r_count[c] <= r_count[c] - 1'b1;
          default: r_count[c] <= r_count[c];
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_rch_q  <= '0;
    end else begin
      r_rvalid <= w_rd_ok;
      if (w_rd_ok) begin
        r_rdata <= r_mem[w_raddr];
        r_rch_q <= i_rch;
      end
    end
  end

  assign o_rdata  = r_rdata;
  assign o_rvalid = r_rvalid;
  assign o_rch_q  = r_rch_q;

`ifdef MCFIFO_ERR_FLAGS_EN
  logic [NUM_CH-1:0] r_overflow;
  logic [NUM_CH-1:0] r_underflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= '0;
      r_underflow <= '0;
    end else if (i_clear) begin
      r_overflow  <= '0;
      r_underflow <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (i_wen && (i_wch == CW'(c)) && o_full[c])  r_overflow[c]  <= 1'b1;
        if (i_ren && (i_rch == CW'(c)) && o_empty[c]) r_underflow[c] <= 1'b1;
      end
    end
  end

  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;
`else
  assign o_overflow  = '0;
  assign o_underflow = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multi_ch_sync_fifo.sv
// tb_multi_ch_sync_fifo: directed vector table, hand sequences and randomized traffic
// checked against a queue-based model of multi_ch_sync_fifo.
`default_nettype none

module tb_multi_ch_sync_fifo;

  localparam int NCH = 4;
  localparam int DEP = 16;
  localparam int AFT = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 clear = 1'b0;
  logic                 wen = 1'b0;
  logic [1:0]           wch = '0;
  logic [7:0]           wdata = '0;
  logic                 ren = 1'b0;
  logic [1:0]           rch = '0;
  logic [7:0]           rdata;
  logic                 rvalid;
  logic [1:0]           rch_q;
  logic [NCH-1:0]       empty, full, afull, overflow, underflow;
  logic [NCH-1:0][4:0]  count;

  multi_ch_sync_fifo dut (
    .clk(clk), .rst(rst), .i_clear(clear),
    .i_wen(wen), .i_wch(wch), .i_wdata(wdata),
    .i_ren(ren), .i_rch(rch),
    .o_rdata(rdata), .o_rvalid(rvalid), .o_rch_q(rch_q),
    .o_empty(empty), .o_full(full), .o_afull(afull), .o_count(count),
    .o_overflow(overflow), .o_underflow(underflow)
  );

  always #5 clk = ~clk;

  // Reference model: one queue per channel plus the registered read outputs.
  logic [7:0] mq [NCH][$];
  logic [7:0] m_rdata = '0;
  logic       m_rvalid = 1'b0;
  logic [1:0] m_rch = '0;
  logic [NCH-1:0] m_ovf = '0, m_unf = '0;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) mq[c].delete();
    m_rdata = '0; m_rvalid = 1'b0; m_rch = '0; m_ovf = '0; m_unf = '0;
  endtask

  task automatic check_model();
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("count[%0d]", c), int'(count[c]), mq[c].size());
      chk($sformatf("empty[%0d]", c), int'(empty[c]), int'(mq[c].size() == 0));
      chk($sformatf("full[%0d]", c),  int'(full[c]),  int'(mq[c].size() == DEP));
      chk($sformatf("afull[%0d]", c), int'(afull[c]), int'(mq[c].size() >= DEP - AFT));
      chk($sformatf("overflow[%0d]", c),  int'(overflow[c]),  int'(m_ovf[c]));
      chk($sformatf("underflow[%0d]", c), int'(underflow[c]), int'(m_unf[c]));
    end
    chk("rvalid", int'(rvalid), int'(m_rvalid));
    chk("rdata",  int'(rdata),  int'(m_rdata));
    chk("rch_q",  int'(rch_q),  int'(m_rch));
  endtask

  // One clock: drive at negedge, model decides from pre-edge state, compare #1 after posedge.
  task automatic step(input logic w, input logic [1:0] wc, input logic [7:0] wd,
                      input logic r, input logic [1:0] rc, input logic clr);
    bit wacc, racc, wfull, rempty;
    @(negedge clk);
    wen = w; wch = wc; wdata = wd; ren = r; rch = rc; clear = clr;
    wfull  = (mq[wc].size() == DEP);
    rempty = (mq[rc].size() == 0);
    wacc = w && !wfull && !clr;
    racc = r && !rempty && !clr;
    @(posedge clk);
    #1;
    if (clr) begin
      for (int c = 0; c < NCH; c++) mq[c].delete();
      m_rvalid = 1'b0; m_ovf = '0; m_unf = '0;
    end else begin
      m_rvalid = racc;
      if (racc) begin
        m_rdata = mq[rc].pop_front();
        m_rch   = rc;
      end
      if (wacc) mq[wc].push_back(wd);
`ifdef MCFIFO_ERR_FLAGS_EN
      if (w && wfull)  m_ovf[wc] = 1'b1;
      if (r && rempty) m_unf[rc] = 1'b1;
`endif
    end
    check_model();
  endtask

  typedef struct {
    logic       w;  logic [1:0] wc; logic [7:0] wd;
    logic       r;  logic [1:0] rc;
    logic       rv; logic [7:0] rd; logic [1:0] cc; int cnt;
  } vec_t;

  vec_t tbl [10];

  initial begin
    tbl[0] = '{1, 1, 8'h11, 0, 0, 0, 8'h00, 1, 1};
    tbl[1] = '{1, 1, 8'h22, 0, 0, 0, 8'h00, 1, 2};
    tbl[2] = '{1, 1, 8'h33, 0, 0, 0, 8'h00, 1, 3};
    tbl[3] = '{0, 0, 8'h00, 1, 1, 1, 8'h11, 1, 2};
    tbl[4] = '{0, 0, 8'h00, 1, 1, 1, 8'h22, 1, 1};
    tbl[5] = '{0, 0, 8'h00, 1, 1, 1, 8'h33, 1, 0};
    tbl[6] = '{1, 0, 8'h5A, 1, 0, 0, 8'h00, 0, 1};
    tbl[7] = '{0, 0, 8'h00, 1, 0, 1, 8'h5A, 0, 0};
    tbl[8] = '{1, 1, 8'hAB, 0, 0, 0, 8'h00, 1, 1};
    tbl[9] = '{1, 0, 8'h01, 1, 1, 1, 8'hAB, 0, 1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_model();

    // Directed table: ch1 ordering, empty same-channel w/r, cross-channel w/r.
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].w, tbl[i].wc, tbl[i].wd, tbl[i].r, tbl[i].rc, 1'b0);
      chk($sformatf("tbl%0d_rvalid", i), int'(rvalid), int'(tbl[i].rv));
      if (tbl[i].rv) begin
        chk($sformatf("tbl%0d_rdata", i), int'(rdata), int'(tbl[i].rd));
        chk($sformatf("tbl%0d_rch_q", i), int'(rch_q), int'(tbl[i].rc));
      end
      chk($sformatf("tbl%0d_count", i), int'(count[tbl[i].cc]), tbl[i].cnt);
    end
    step(0, 0, 0, 1, 0, 0);

    // Fill ch2 to full, overflow attempt, then first word out.
    for (int i = 0; i < DEP; i++) begin
      step(1, 2, 8'hC0 + 8'(i), 0, 0, 0);
      chk("fill2_afull", int'(afull[2]), int'(i + 1 >= DEP - AFT));
    end
    chk("fill2_full", int'(full[2]), 1);
    step(1, 2, 8'hEE, 0, 0, 0);
    chk("ovf2_count", int'(count[2]), DEP);
    step(0, 0, 0, 1, 2, 0);
    chk("ovf2_first", int'(rdata), 8'hC0);

    // Full ch3: same-cycle w/r rejects the write; then pointer-wrap traffic.
    for (int i = 0; i < DEP; i++) step(1, 3, 8'h30 + 8'(i), 0, 0, 0);
    step(1, 3, 8'hFF, 1, 3, 0);
    chk("full3_count", int'(count[3]), DEP - 1);
    chk("full3_rdata", int'(rdata), 8'h30);
    for (int i = 0; i < 40; i++) begin
      step(1, 3, 8'(i * 7), 0, 0, 0);
      step(0, 0, 0, 1, 3, 0);
    end

    // Clear during traffic.
    step(1, 0, 8'h77, 1, 2, 1);
    chk("clr_rvalid", int'(rvalid), 0);
    chk("clr_empty", int'(empty), 4'hF);

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 500; i++) begin
      step(1'($urandom_range(0, 99) < 60), 2'($urandom), 8'($urandom),
           1'($urandom_range(0, 99) < 50), 2'($urandom), 1'($urandom_range(0, 99) < 2));
    end

    // Async reset mid-read.
    step(1, 0, 8'h9C, 0, 0, 0);
    step(1, 0, 8'h9D, 1, 0, 0);
    @(negedge clk);
    ren = 1'b1; rch = 2'd0; wen = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_rvalid", int'(rvalid), 0);
    chk("arst_rdata", int'(rdata), 0);
    check_model();
    @(negedge clk);
    ren = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0, 1, 0, 0);
    chk("post_rst_rvalid", int'(rvalid), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multi_ch_sync_fifo.md
# multi_ch_sync_fifo

Single-clock FIFO holding NUM_CH independent logical queues in one shared storage array, statically partitioned CH_DEPTH entries per channel. It is the multi-channel successor to the team's single-queue sync FIFO: one write and one read per cycle, each steered by a channel index, with a registered read path. Per-channel status flags feed per-channel arbiters and flow control in the datapath.

## Interface
- DTYPE, logic[7:0], entry type
- NUM_CH, 4, number of logical channels (>=1)
- CH_DEPTH, 16, entries per channel (>=2, need not be a power of two)
- CH_AW, $clog2(CH_DEPTH), per-channel pointer width
- CW, (NUM_CH>1 ? $clog2(NUM_CH) : 1), channel index width
- AFULL_TH, 2, almost-full margin; afull[c] = count[c] >= CH_DEPTH-AFULL_TH
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- clear  in  1  synchronous flush of all channels
- wen  in  1  write request
- wch  in  CW  write channel index
- wdata  in  DTYPE  write data
- ren  in  1  read request
- rch  in  CW  read channel index
- rdata  out  DTYPE  registered read data
- rvalid  out  1  rdata valid this cycle
- rch_q  out  CW  channel tag of rdata
- empty  out  [NUM_CH]  per-channel empty
- full  out  [NUM_CH]  per-channel full
- afull  out  [NUM_CH]  per-channel almost full
- count  out  [NUM_CH][CH_AW+1]  per-channel occupancy
- overflow  out  [NUM_CH]  sticky write-while-full flag
- underflow  out  [NUM_CH]  sticky read-while-empty flag

## Operation
- Storage: NUM_CH*CH_DEPTH entries; physical address = ch*CH_DEPTH + ptr.
- Per channel: wptr, rptr (CH_AW bits), count (CH_AW+1 bits). Pointer increments wrap CH_DEPTH-1 -> 0 explicitly.
- Write accepted iff wen && wch<NUM_CH && !full[wch]; stores wdata at wptr[wch], increments wptr[wch].
- Read accepted iff ren && rch<NUM_CH && !empty[rch]; captures entry at rptr[rch] into rdata, increments rptr[rch].
- Flags decoded from current (registered) count: empty = count==0, full = count==CH_DEPTH.
- Count update per channel: +1 write only, -1 read only, unchanged for both or neither.
- Same channel, same cycle: empty channel -> read rejected, write accepted (no bypass); full channel -> write rejected, read accepted.
- Different channels in the same cycle update independently.
- Out-of-range index (>=NUM_CH): request ignored, no state change, no error flag.
- clear: zeros all pointers and counts next edge, blocks same-cycle accepts, rvalid=0 next cycle, clears error flags; memory contents untouched.
- Reset values: all pointers/counts 0, empty all 1, full/afull all 0, rdata 0, rvalid 0, rch_q 0, overflow/underflow 0.

## Timing
- Read latency 1: accepted read at edge N -> rdata/rvalid/rch_q valid after edge N, for exactly one cycle per accept; rdata holds last value when rvalid=0.
- Write at edge N visible to a read accepted at edge N+1 or later.
- Flags/count reflect state after the last edge; combinational only from registers.
- Back-to-back reads of one channel: one word per cycle, rvalid continuously high.
- Reset mid-operation: immediate return to reset values, in-flight read dropped.

## Configuration
- MCFIFO_ERR_FLAGS_EN defined: overflow[c] sets on wen && wch==c && full[c]; underflow[c] sets on ren && rch==c && empty[c]; both sticky until clear or rst.
- Not defined: overflow and underflow driven constant 0, no flag registers.

## Test plan
- Reset, write 0x11,0x22,0x33 to ch1, read ch1 x3 -> rdata 0x11,0x22,0x33 on consecutive cycles, rvalid=1, rch_q=1, count[1] back to 0, other channels untouched.
- Fill ch2 with 16 writes -> full[2]=1 after 16th, afull[2]=1 from count 14; 17th write ignored (overflow[2]=1 with macro); read returns first word.
- Empty ch0, simultaneous wen/ren on ch0 -> read rejected, rvalid=0, count[0]=1; next cycle read returns the written word.
- Full ch3, simultaneous wen/ren on ch3 -> write rejected, count[3] 16->15; wrap: 40 interleaved write/read pairs keep order across pointer wrap.
- Write ch0 and read ch1 same cycle with ch1 holding 0xAB -> count[0]+1, count[1]-1, rdata=0xAB.
- Mid-traffic clear -> all counts 0, empty all 1, rvalid 0 next cycle, error flags cleared; async rst assertion mid-read -> rvalid 0 immediately.
